dsm_modulator_2nd: RTL and testbench

Second-order digital delta-sigma modulator. It is the encoder side of the team's decimation chain (CIC + LPF): it turns multi-bit PCM samples into the 1-bit oversampled bitstream that the decimator consumes. It is used as the stimulus source for closed-loop decimator benches, and as a DAC-path modulator. It requests one input sample per OSR output bits and emits one bit per clock while running.

---
 rtl/dsm_pkg.sv | 51 +++++
 rtl/dsm_lfsr_dither.sv | 33 +++
 rtl/dsm_modulator_2nd.sv | 163 ++++++++++++++++
 tb/tb_dsm_modulator_2nd.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg: shared types, constants and helpers for the second-order
// delta-sigma modulator and its optional dither source (DSM_DITHER_EN).
package dsm_pkg;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dsm_state_t;

    // Internal arithmetic width. Every integrator term is sign-extended to this
    // width before summing, so ACC_WIDTH must be at most CALC_W-2.
    localparam int CALC_W = 32;

    // 16-bit Galois LFSR: taps 16,14,13,11 -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Saturation result: clamped value plus a flag that the clamp engaged.
    typedef struct packed {
        logic signed [CALC_W-1:0] val;
        logic                     clamp;
    } sat_t;

    // Full scale of a signed word of width in_w: 2^(in_w-1).
    function automatic logic signed [CALC_W-1:0] fs_of(input int in_w);
        logic [CALC_W-1:0] v;
        v = '0;
        v[in_w-1] = 1'b1;
        return $signed(v);
    endfunction

    // Symmetric saturation to +/-(2^(acc_w-1)-1).
    function automatic sat_t sat_acc(input logic signed [CALC_W-1:0] x, input int acc_w);
        logic signed [CALC_W-1:0] lim;
        sat_t r;
        lim = fs_of(acc_w) - 32'sd1;
        if (x > lim) begin
            r.val   = lim;
            r.clamp = 1'b1;
        end else if (x < -lim) begin
            r.val   = -lim;
            r.clamp = 1'b1;
        end else begin
            r.val   = x;
            r.clamp = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsm_lfsr_dither.sv
// dsm_lfsr_dither: Galois LFSR producing a signed 4-bit dither word
// (lfsr[3:0]-8) scaled by 2^(INPUT_WIDTH-6). Only built with DSM_DITHER_EN.
module dsm_lfsr_dither
    import dsm_pkg::*;
#(
    parameter int INPUT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_adv,
    input  logic              i_reseed,
    output logic [CALC_W-1:0] o_dither
);

    logic [15:0] r_lfsr;
    logic [3:0]  w_d4;

    // LFSR: reseed on reset or when the modulator is disabled, step each RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_reseed) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_adv) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // lfsr[3:0]-8 in two's complement is the nibble with its MSB inverted.
    assign w_d4     = {~r_lfsr[3], r_lfsr[2:0]};
    assign o_dither = {{(CALC_W-4){w_d4[3]}}, w_d4} << (INPUT_WIDTH - 6);

endmodule

// File: rtl/dsm_modulator_2nd.sv
// dsm_modulator_2nd: second-order 1-bit delta-sigma modulator turning signed
// PCM samples into an oversampled bitstream (one bit per clock in RUN).
// Optional quantizer dither: define DSM_DITHER_EN.
//
// Handshake: sample_req is high for exactly one cycle every OSR output bits.
// A sample is taken on any RUN edge where data_in_valid=1 (the block never
// stalls, so there is no ready). A valid on the sample_req edge is on time; if
// the request edge sees neither a valid nor an earlier sample in this window,
// underrun_flag sets and the previous sample is held. d_out is meaningful only
// while data_out_valid=1.
module dsm_modulator_2nd
    import dsm_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int ACC_WIDTH   = INPUT_WIDTH + 4,
    parameter int OSR         = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [INPUT_WIDTH-1:0] d_in,
    input  logic                   data_in_valid,
    output logic                   sample_req,
    output logic                   d_out,
    output logic                   data_out_valid,
    output logic                   ovf_flag,
    output logic                   underrun_flag
);

    localparam int                       CNT_W    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(OSR - 1);
    localparam logic signed [CALC_W-1:0] FS       = fs_of(INPUT_WIDTH);

    dsm_state_t                  r_state;
    logic signed [ACC_WIDTH-1:0] r_i1;
    logic signed [ACC_WIDTH-1:0] r_i2;
    logic [INPUT_WIDTH-1:0]      r_x_hold;
    logic [CNT_W-1:0]            r_osr_cnt;
    logic                        r_fresh;
    logic                        r_d_out;
    logic                        r_dout_valid;
    logic                        r_ovf;
    logic                        r_underrun;

    logic signed [CALC_W-1:0]    w_i1_ext;
    logic signed [CALC_W-1:0]    w_i2_ext;
    logic signed [CALC_W-1:0]    w_x_ext;
    logic signed [CALC_W-1:0]    w_fb;
    logic signed [CALC_W-1:0]    w_sum1;
    logic signed [CALC_W-1:0]    w_sum2;
    sat_t                        w_sat1;
    sat_t                        w_sat2;
    logic                        w_y;
    logic                        w_run;
    logic                        w_req;
    logic                        w_unused;

    assign w_run = (r_state == ST_RUN) && en;
    assign w_req = (r_state == ST_RUN) && (r_osr_cnt == CNT_LAST);

    assign w_i1_ext = {{(CALC_W-ACC_WIDTH){r_i1[ACC_WIDTH-1]}}, r_i1};
    assign w_i2_ext = {{(CALC_W-ACC_WIDTH){r_i2[ACC_WIDTH-1]}}, r_i2};
    assign w_x_ext  = {{(CALC_W-INPUT_WIDTH){r_x_hold[INPUT_WIDTH-1]}}, r_x_hold};

`ifdef DSM_DITHER_EN
    logic signed [CALC_W-1:0] w_dither;
    logic signed [CALC_W-1:0] w_q;

    dsm_lfsr_dither #(
        .INPUT_WIDTH(INPUT_WIDTH)
    ) u_dither (
        .clk      (clk),
        .rst      (rst),
        .i_adv    (w_run),
        .i_reseed (~en),
        .o_dither (w_dither)
    );

    // Dither only moves the quantizer threshold; integrators see plain feedback.
    assign w_q = w_i2_ext + w_dither;
    assign w_y = ~w_q[CALC_W-1];
`else
    assign w_y = ~r_i2[ACC_WIDTH-1];
`endif

    assign w_fb   = w_y ? FS : -FS;
    assign w_sum1 = w_i1_ext + w_x_ext - w_fb;
    assign w_sum2 = w_i2_ext + w_i1_ext - (w_fb <<< 1);
    assign w_sat1 = sat_acc(w_sum1, ACC_WIDTH);
    assign w_sat2 = sat_acc(w_sum2, ACC_WIDTH);

    // After saturation the upper bits are pure sign copies.
    assign w_unused = ^{w_sat1.val[CALC_W-1:ACC_WIDTH], w_sat2.val[CALC_W-1:ACC_WIDTH]};

    // Controller, integrators, OSR counter and input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_i1         <= '0;
            r_i2         <= '0;
            r_x_hold     <= '0;
            r_osr_cnt    <= '0;
            r_fresh      <= 1'b0;
            r_d_out      <= 1'b0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_d_out      <= 1'b0;
                    r_dout_valid <= 1'b0;
                    if (en && data_in_valid) begin
                        r_x_hold <= d_in;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        r_state      <= ST_IDLE;
                        r_i1         <= '0;
                        r_i2         <= '0;
                        r_osr_cnt    <= '0;
                        r_fresh      <= 1'b0;
                        r_ovf        <= 1'b0;
                        r_underrun   <= 1'b0;
                        r_d_out      <= 1'b0;
                        r_dout_valid <= 1'b0;
                    end else begin
                        r_i1         <= w_sat1.val[ACC_WIDTH-1:0];
                        r_i2         <= w_sat2.val[ACC_WIDTH-1:0];
                        r_d_out      <= w_y;
                        r_dout_valid <= 1'b1;
                        if (w_sat1.clamp || w_sat2.clamp) begin
                            r_ovf <= 1'b1;
                        end
                        r_osr_cnt <= (r_osr_cnt == CNT_LAST) ? '0 : r_osr_cnt + 1'b1;
                        if (w_req) begin
                            // Request edge closes the window; zero-order hold on a miss.
                            if (data_in_valid) begin
                                r_x_hold <= d_in;
                            end else if (!r_fresh) begin
                                r_underrun <= 1'b1;
                            end
                            r_fresh <= 1'b0;
                        end else if (data_in_valid) begin
                            r_x_hold <= d_in;
                            r_fresh  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sample_req     = w_req;
    assign d_out          = r_d_out;
    assign data_out_valid = r_dout_valid;
    assign ovf_flag       = r_ovf;
    assign underrun_flag  = r_underrun;

endmodule

// File: tb/tb_dsm_modulator_2nd.sv
// tb_dsm_modulator_2nd: directed bench for dsm_modulator_2nd (default build).
// Expected bitstreams are the hand-derived loop cycles for 0 and +0.5*FS input.
module tb_dsm_modulator_2nd;

    localparam int IW = 16;

    logic          clk           = 1'b0;
    logic          rst           = 1'b1;
    logic          en            = 1'b0;
    logic [IW-1:0] d_in          = '0;
    logic          data_in_valid = 1'b0;
    logic          sample_req;
    logic          d_out;
    logic          data_out_valid;
    logic          ovf_flag;
    logic          underrun_flag;

    int checks    = 0;
    int failures  = 0;
    int bits_cnt  = 0;
    int ones_cnt  = 0;
    int n_req     = 0;
    int edge_cnt  = 0;
    int first_req = 0;
    logic chk_bits = 1'b1;

    logic [0:0] exp_q[$];
    logic       pat_zero[4];
    logic       pat_half[8];

    dsm_modulator_2nd #(
        .INPUT_WIDTH(IW),
        .ACC_WIDTH  (IW + 4),
        .OSR        (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .d_in           (d_in),
        .data_in_valid  (data_in_valid),
        .sample_req     (sample_req),
        .d_out          (d_out),
        .data_out_valid (data_out_valid),
        .ovf_flag       (ovf_flag),
        .underrun_flag  (underrun_flag)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Advance one cycle; land 1 time unit after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Push n expected bits of a periodic pattern starting at bit offset start.
    task automatic push_pat(input int start, input int n, input int sel);
        for (int i = start; i < start + n; i++) begin
            if (sel == 0) exp_q.push_back(pat_zero[i % 4]);
            else          exp_q.push_back(pat_half[i % 8]);
        end
    endtask

    task automatic start_run(input logic [IW-1:0] x);
        en            = 1'b1;
        data_in_valid = 1'b1;
        d_in          = x;
        edge_cnt      = 0;
        first_req     = 0;
        n_req         = 0;
        tick();
        data_in_valid = 1'b0;
    endtask

    // Run n edges, answering at most max_supply requests coincidentally.
    task automatic run_cycles(input int n, input logic [IW-1:0] x, input int max_supply);
        for (int i = 0; i < n; i++) begin
            tick();
            edge_cnt++;
            data_in_valid = 1'b0;
            if (sample_req) begin
                if (first_req == 0) first_req = edge_cnt;
                if (n_req < max_supply) begin
                    data_in_valid = 1'b1;
                    d_in          = x;
                end
                n_req++;
            end
        end
    endtask

    task automatic stop_run();
        en            = 1'b0;
        data_in_valid = 1'b0;
        tick();
    endtask

    task automatic check_drain(input string name);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pop one expected bit for every valid output bit.
    initial begin
        logic [0:0] exp_bit;
        forever begin
            @(negedge clk);
            if (data_out_valid === 1'b1) begin
                bits_cnt++;
                if (d_out) ones_cnt++;
                if (chk_bits) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bit_unexpected actual=%0b required=none", d_out);
                    end else begin
                        exp_bit = exp_q.pop_front();
                        check("bit", int'(d_out), int'(exp_bit));
                    end
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        pat_zero = '{1'b1, 1'b0, 1'b0, 1'b1};
        pat_half = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        repeat (3) tick();
        check("rst_d_out", d_out, 0);
        check("rst_dout_valid", data_out_valid, 0);
        check("rst_sample_req", sample_req, 0);
        check("rst_ovf", ovf_flag, 0);
        check("rst_underrun", underrun_flag, 0);
        rst = 1'b0;
        tick();

        // Zero input, latency and first request.
        push_pat(0, 128, 0);
        start_run('0);
        check("dout_valid_at_e0", data_out_valid, 0);
        run_cycles(128, '0, 1000);
        check("first_req_edge", first_req, 63);
        check("zero_ovf", ovf_flag, 0);
        check("zero_underrun", underrun_flag, 0);

        // Async reset between edges, then the zero-input run again.
        push_pat(128, 21, 0);
        run_cycles(21, '0, 1000);
        rst = 1'b1;
        #1;
        check("arst_d_out", d_out, 0);
        check("arst_dout_valid", data_out_valid, 0);
        check("arst_sample_req", sample_req, 0);
        check("arst_ovf", ovf_flag, 0);
        check("arst_underrun", underrun_flag, 0);
        tick();
        rst = 1'b0;
        check_drain("drain_before_rerun");
        push_pat(0, 32, 0);
        start_run('0);
        run_cycles(32, '0, 1000);
        check_drain("drain_rerun");
        stop_run();
        check("stop_dout_valid", data_out_valid, 0);

        // DC +0.5*FS: cycle 1,0,0,1,1,1,1,1 -> density 0.75.
        bits_cnt = 0;
        ones_cnt = 0;
        push_pat(0, 4096, 1);
        start_run(16'sd16384);
        run_cycles(4096, 16'sd16384, 100000);
        check("half_bits", bits_cnt, 4096);
        check("half_density_in_range", int'(ones_cnt >= 3052 && ones_cnt <= 3092), 1);
        check("half_ovf", ovf_flag, 0);
        check("half_underrun", underrun_flag, 0);
        check_drain("drain_half");
        stop_run();

        // Underrun: three on-time samples, then none; the held sample keeps the cycle.
        push_pat(0, 300, 1);
        start_run(16'sd16384);
        run_cycles(255, 16'sd16384, 3);
        check("underrun_before_4th_req", underrun_flag, 0);
        run_cycles(1, 16'sd16384, 3);
        check("underrun_at_4th_req", underrun_flag, 1);
        run_cycles(44, 16'sd16384, 3);
        check_drain("drain_underrun");
        check("underrun_ovf", ovf_flag, 0);
        stop_run();
        check("underrun_cleared_by_en", underrun_flag, 0);

        // Overload: full-scale input saturates the loop; en=0 clears the flags.
        chk_bits = 1'b0;
        start_run(16'sd32767);
        run_cycles(200, 16'sd32767, 0);
        check("overload_ovf", ovf_flag, 1);
        check("overload_underrun", underrun_flag, 1);
        check("overload_no_x",
              int'($isunknown({d_out, data_out_valid, sample_req, ovf_flag, underrun_flag})), 0);
        stop_run();
        check("overload_clr_dout_valid", data_out_valid, 0);
        check("overload_clr_ovf", ovf_flag, 0);
        check("overload_clr_underrun", underrun_flag, 0);
        check("overload_clr_sample_req", sample_req, 0);
        chk_bits = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
